apb_demux_pipe: RTL and testbench

Registered, parametrised APB3 1-to-N demultiplexer. Sits between one upstream APB requester and SLAVE_COUNT downstream APB completers. Decodes PADDR against a linear address map and re-issues each transfer downstream with a proper SETUP/ACCESS sequence. Returns PRDATA/PSLVERR upstream, flags unmapped addresses with PSLVERR, and optionally aborts hung completers with a timeout error.

---
 rtl/apb_demux_pkg.sv | 33 +++
 rtl/apb_demux_pipe_if.sv | 37 +++
 rtl/apb_addr_decoder.sv | 40 ++++
 rtl/apb_demux_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_apb_demux_pipe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_demux_pkg.sv
// -----------------------------------------------------------------------------
// apb_demux_pkg
//
// Shared types for the registered APB3 1-to-N demultiplexer:
//   state_e     - transfer sequencer states
//   resp_t      - response captured from a completer {prdata, pslverr}
//   idx_width() - width of a completer index, never less than one bit
//
// resp_t carries RESP_DATA_WIDTH bits of read data. The demux is used with
// DATA_WIDTH equal to RESP_DATA_WIDTH.
// -----------------------------------------------------------------------------
package apb_demux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        DECERR
    } state_e;

    localparam int unsigned RESP_DATA_WIDTH = 32;

    typedef struct packed {
        logic [RESP_DATA_WIDTH-1:0] prdata;
        logic                       pslverr;
    } resp_t;

    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/apb_demux_pipe_if.sv
// -----------------------------------------------------------------------------
// apb_demux_pipe_if
//
// APB3 bus bundle. SEL_COUNT sets the width of the select and per-completer
// response vectors: 1 for the upstream side, SLAVE_COUNT for the downstream
// side, where prdata packs completer i at [i*DATA_WIDTH +: DATA_WIDTH].
//
// Modports:
//   master - drives psel/penable/pwrite/paddr/pwdata, receives pready/pslverr/prdata
//   slave  - receives the request, drives pready/pslverr/prdata
// -----------------------------------------------------------------------------
interface apb_demux_pipe_if #(
    parameter int unsigned SEL_COUNT  = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [SEL_COUNT-1:0]            psel;
    logic                            penable;
    logic                            pwrite;
    logic [ADDR_WIDTH-1:0]           paddr;
    logic [DATA_WIDTH-1:0]           pwdata;
    logic [SEL_COUNT-1:0]            pready;
    logic [SEL_COUNT-1:0]            pslverr;
    logic [SEL_COUNT*DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// -----------------------------------------------------------------------------
// apb_addr_decoder
//
// Combinational decode of an upstream address against a linear map of
// SLAVE_COUNT regions, each SLAVE_SPAN bytes, starting at BASE_ADDR.
//
// Ports:
//   addr   in  ADDR_WIDTH  upstream byte address
//   hit    out 1           address falls inside the mapped window
//   index  out IDX_W       completer number (valid when hit)
//   offset out ADDR_WIDTH  address relative to the completer's region base
// -----------------------------------------------------------------------------
module apb_addr_decoder
    import apb_demux_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            SLAVE_SPAN  = 'h80,
    parameter int unsigned            SLAVE_COUNT = 3,
    localparam int unsigned           IDX_W       = idx_width(SLAVE_COUNT)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index,
    output logic [ADDR_WIDTH-1:0] offset
);

    localparam int unsigned     SPAN_SHIFT   = $clog2(SLAVE_SPAN);
    localparam longint unsigned REGION_BYTES = longint'(SLAVE_COUNT) * longint'(SLAVE_SPAN);

    logic [ADDR_WIDTH-1:0] rel;

    // The window size is compared one bit wider so a map reaching the very
    // top of the address space does not wrap to zero.
    assign rel    = addr - BASE_ADDR;
    assign hit    = (addr >= BASE_ADDR) && ({1'b0, rel} < (ADDR_WIDTH+1)'(REGION_BYTES));
    assign index  = IDX_W'(rel >> SPAN_SHIFT);
    assign offset = rel & ADDR_WIDTH'(SLAVE_SPAN - 1);

endmodule

// File: rtl/apb_demux_pipe.sv
// -----------------------------------------------------------------------------
// apb_demux_pipe
//
// Registered APB3 1-to-SLAVE_COUNT demultiplexer. Each upstream transfer is
// decoded, then re-issued downstream as a fresh SETUP/ACCESS pair with the
// region-local address. The selected completer's response is registered and
// returned upstream one cycle later. Unmapped addresses complete at once with
// an error and no downstream activity.
//
// Build option: define APB_DEMUX_TIMEOUT_EN to abort a completer that holds
// pready low for TIMEOUT_CYCLES ACCESS cycles; the abort returns pslverr=1
// and pulses timeout_o. Without it, ACCESS waits indefinitely.
//
// Ports:
//   PCLK       in   clock, rising edge
//   PRESETn    in   synchronous active-low reset
//   s_apb      slave modport  - upstream requester (SEL_COUNT = 1)
//   m_apb      master modport - downstream completers (SEL_COUNT = SLAVE_COUNT)
//   timeout_o  out  one-cycle pulse on a timeout abort
// -----------------------------------------------------------------------------
module apb_demux_pipe
    import apb_demux_pkg::*;
#(
    parameter int unsigned           SLAVE_COUNT    = 3,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           SLAVE_SPAN     = 'h80,
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_demux_pipe_if.slave   s_apb,
    apb_demux_pipe_if.master  m_apb,
    output logic              timeout_o
);

    localparam int unsigned IDX_W = idx_width(SLAVE_COUNT);

    // Elaboration-time parameter sanity checks.
    if (SLAVE_COUNT < 1) begin : g_bad_count
        $error("apb_demux_pipe: SLAVE_COUNT must be at least 1");
    end
    if (SLAVE_SPAN < 4 || (SLAVE_SPAN & (SLAVE_SPAN - 1)) != 0) begin : g_bad_span
        $error("apb_demux_pipe: SLAVE_SPAN must be a power of two, at least 4");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_demux_pipe: TIMEOUT_CYCLES must be at least 2");
    end
    if (DATA_WIDTH != RESP_DATA_WIDTH) begin : g_bad_width
        $error("apb_demux_pipe: DATA_WIDTH must equal RESP_DATA_WIDTH");
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [ADDR_WIDTH-1:0] dec_offset;

    apb_addr_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE_ADDR   (BASE_ADDR),
        .SLAVE_SPAN  (SLAVE_SPAN),
        .SLAVE_COUNT (SLAVE_COUNT)
    ) u_decoder (
        .addr   (s_apb.paddr),
        .hit    (dec_hit),
        .index  (dec_idx),
        .offset (dec_offset)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    resp_t                 resp_q, resp_d;

`ifdef APB_DEMUX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Only the currently selected completer's response is looked at.
    logic                  up_setup;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign up_setup  = s_apb.psel[0] && !s_apb.penable;
    assign sel_ready = m_apb.pready[idx_q];
    assign sel_err   = m_apb.pslverr[idx_q];
    assign sel_rdata = m_apb.prdata[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        resp_d   = resp_q;
`ifdef APB_DEMUX_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (up_setup) begin
                    if (dec_hit) begin
                        // Downstream address/control only change for a mapped
                        // transfer, so they hold across unmapped accesses.
                        idx_d    = dec_idx;
                        addr_d   = dec_offset;
                        pwrite_d = s_apb.pwrite;
                        pwdata_d = s_apb.pwdata;
                        state_d  = SETUP;
`ifdef APB_DEMUX_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        state_d = DECERR;
                    end
                end
            end

            SETUP: state_d = ACCESS;

            ACCESS: begin
                if (sel_ready) begin
                    resp_d.prdata  = pwrite_q ? '0 : RESP_DATA_WIDTH'(sel_rdata);
                    resp_d.pslverr = sel_err;
                    state_d        = RESP;
                end
`ifdef APB_DEMUX_TIMEOUT_EN
                // A ready arriving on the limit cycle takes priority above.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_d.prdata  = '0;
                    resp_d.pslverr = 1'b1;
                    timeout_d      = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            RESP:    state_d = IDLE;
            DECERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            resp_q   <= '0;
`ifdef APB_DEMUX_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            resp_q   <= resp_d;
`ifdef APB_DEMUX_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only, so all are zero after reset.
    // ------------------------------------------------------------------
    logic downstream_active;

    assign downstream_active = (state_q == SETUP) || (state_q == ACCESS);

    assign m_apb.psel    = downstream_active ? (SLAVE_COUNT'(1) << idx_q) : '0;
    assign m_apb.penable = (state_q == ACCESS);
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.paddr   = addr_q;
    assign m_apb.pwdata  = pwdata_q;

    assign s_apb.pready  = (state_q == RESP) || (state_q == DECERR);
    assign s_apb.pslverr = (state_q == DECERR) || ((state_q == RESP) && resp_q.pslverr);
    assign s_apb.prdata  = (state_q == RESP) ? resp_q.prdata[DATA_WIDTH-1:0] : '0;

`ifdef APB_DEMUX_TIMEOUT_EN
    // timeout_q is set only on the edge entering RESP, which lasts one cycle.
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_demux_pipe.sv
// -----------------------------------------------------------------------------
// tb_apb_demux_pipe
//
// Self-checking bench for apb_demux_pipe: directed scenarios followed by a
// randomized run, all compared against a transfer-level model of the address
// map and response timing. Completers are modelled per index with a
// configurable number of wait cycles, read data and error flag; unselected
// completers drive random noise on their response lines.
// -----------------------------------------------------------------------------
module tb_apb_demux_pipe;

    localparam int unsigned SC    = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam longint      BASE  = 0;
    localparam longint      SPAN  = 'h80;
    localparam int          TO    = 4;
    localparam int          LIMIT = 64;
`ifdef APB_DEMUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    logic timeout_o;

    int checks   = 0;
    int failures = 0;

    apb_demux_pipe_if #(.SEL_COUNT(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    apb_demux_pipe_if #(.SEL_COUNT(SC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();

    apb_demux_pipe #(
        .SLAVE_COUNT    (SC),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BASE_ADDR      (AW'(BASE)),
        .SLAVE_SPAN     (int'(SPAN)),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .s_apb     (s_bus),
        .m_apb     (m_bus),
        .timeout_o (timeout_o)
    );

    always #5 PCLK = ~PCLK;

    // ------------------------------------------------------------------
    // Completer models
    // ------------------------------------------------------------------
    int unsigned   wait_cfg  [SC];
    logic [31:0]   rdata_cfg [SC];
    logic          err_cfg   [SC];
    int unsigned   acc_cnt   [SC];
    logic [SC-1:0] noise;
    logic [SC-1:0]    pready_v, pslverr_v;
    logic [SC*DW-1:0] prdata_v;

    always @(posedge PCLK) begin
        for (int i = 0; i < SC; i++)
            acc_cnt[i] <= (m_bus.psel[i] && m_bus.penable) ? acc_cnt[i] + 1 : 0;
    end

    always_comb begin
        pready_v  = '0;
        pslverr_v = '0;
        prdata_v  = '0;
        for (int i = 0; i < SC; i++) begin
            if (m_bus.psel[i] && m_bus.penable) begin
                pready_v[i]             = (acc_cnt[i] >= wait_cfg[i]);
                pslverr_v[i]            = err_cfg[i];
                prdata_v[i*DW +: DW]    = rdata_cfg[i];
            end else begin
                pready_v[i]             = noise[i];
                pslverr_v[i]            = noise[i];
                prdata_v[i*DW +: DW]    = ~rdata_cfg[i];
            end
        end
    end

    assign m_bus.pready  = pready_v;
    assign m_bus.pslverr = pslverr_v;
    assign m_bus.prdata  = prdata_v;

    initial begin
        noise = '0;
        forever begin
            @(posedge PCLK);
            #2 noise = SC'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: expected upstream result of one transfer.
    // ------------------------------------------------------------------
    function automatic bit addr_hit(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a >= BASE) && (a < BASE + SC * SPAN);
    endfunction

    task automatic model(input logic [31:0] addr, input logic write,
                         output int ws, output logic [31:0] rdata,
                         output logic err, output logic tmo);
        int idx;
        if (!addr_hit(addr)) begin
            ws = 0; rdata = '0; err = 1'b1; tmo = 1'b0;
        end else begin
            idx = int'((longint'(addr) - BASE) / SPAN);
            if (TO_EN && wait_cfg[idx] >= TO) begin
                ws = 1 + TO; rdata = '0; err = 1'b1; tmo = 1'b1;
            end else begin
                ws    = 2 + int'(wait_cfg[idx]);
                rdata = write ? 32'h0 : rdata_cfg[idx];
                err   = err_cfg[idx];
                tmo   = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Upstream driver. Returns what was observed; bad counts cycles where
    // the downstream bus or idle upstream outputs differed from the model.
    // Entered just after a rising edge; leaves just after a rising edge.
    // ------------------------------------------------------------------
    task automatic run_xfer(input logic [31:0] addr, input logic write,
                            input logic [31:0] wdata, input bit drop,
                            output int ws, output logic [31:0] rdata,
                            output logic err, output logic tmo, output int bad,
                            output logic [SC-1:0] psel_seen,
                            output logic [31:0] paddr_seen);
        bit            hit;
        int            idx;
        logic [31:0]   off;
        logic [SC-1:0] oh;
        hit = addr_hit(addr);
        idx = hit ? int'((longint'(addr) - BASE) / SPAN) : 0;
        off = 32'((longint'(addr) - BASE) % SPAN);
        oh  = hit ? (SC'(1) << idx) : '0;

        ws = -1; rdata = '0; err = 1'b0; tmo = 1'b0; bad = 0;
        psel_seen = '0; paddr_seen = '0;

        s_bus.psel    = 1'b1;
        s_bus.penable = 1'b0;
        s_bus.pwrite  = write;
        s_bus.paddr   = addr;
        s_bus.pwdata  = wdata;
        @(posedge PCLK);
        #1;
        if (drop) begin
            s_bus.psel    = 1'b0;
            s_bus.penable = 1'b0;
        end else begin
            s_bus.penable = 1'b1;
        end

        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge PCLK);
            if (k == 1) begin
                psel_seen  = m_bus.psel;
                paddr_seen = m_bus.paddr;
            end
            if (s_bus.pready[0] === 1'b1) begin
                ws    = k - 1;
                rdata = s_bus.prdata;
                err   = s_bus.pslverr[0];
                tmo   = timeout_o;
                if (m_bus.psel !== '0 || m_bus.penable !== 1'b0) bad++;
                break;
            end
            if (s_bus.prdata !== '0 || timeout_o !== 1'b0) bad++;
            if (!hit) bad++;
            else if (m_bus.psel !== oh || m_bus.penable !== (k >= 2) ||
                     m_bus.paddr !== off || m_bus.pwrite !== write ||
                     m_bus.pwdata !== wdata) bad++;
        end
        @(posedge PCLK);
        #1;
        s_bus.psel    = 1'b0;
        s_bus.penable = 1'b0;
    endtask

    // Result holders shared by the sequential test tasks.
    int            r_ws, r_bad;
    logic [31:0]   r_rdata, r_paddr;
    logic          r_err, r_tmo;
    logic [SC-1:0] r_psel;

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({s_bus.pready, s_bus.pslverr, s_bus.prdata} !== '0) begin
            failures++;
            $display("FAIL reset_upstream got=%h exp=0", {s_bus.pready, s_bus.pslverr, s_bus.prdata});
        end
        checks++;
        if ({m_bus.psel, m_bus.penable, m_bus.pwrite, m_bus.paddr, m_bus.pwdata, timeout_o} !== '0) begin
            failures++;
            $display("FAIL reset_downstream got=%h exp=0",
                     {m_bus.psel, m_bus.penable, m_bus.pwrite, m_bus.paddr, m_bus.pwdata, timeout_o});
        end
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    task automatic test_read_c1();
        wait_cfg[1] = 0; rdata_cfg[1] = 32'hCAFE0001; err_cfg[1] = 1'b0;
        run_xfer(32'h84, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_psel !== 3'b010) begin failures++; $display("FAIL read_c1_psel got=%b exp=010", r_psel); end
        checks++;
        if (r_paddr !== 32'h4) begin failures++; $display("FAIL read_c1_paddr got=%h exp=4", r_paddr); end
        checks++;
        if (r_ws !== 2) begin failures++; $display("FAIL read_c1_waits got=%0d exp=2", r_ws); end
        checks++;
        if (r_rdata !== 32'hCAFE0001 || r_err !== 1'b0) begin
            failures++; $display("FAIL read_c1_resp got=%h/%b exp=cafe0001/0", r_rdata, r_err);
        end
        checks++;
        if (r_bad !== 0) begin failures++; $display("FAIL read_c1_bus got=%0d bad cycles exp=0", r_bad); end
    endtask

    task automatic test_write_wait();
        wait_cfg[2] = 3; rdata_cfg[2] = 32'h5A5A5A5A; err_cfg[2] = 1'b0;
        run_xfer(32'h100, 1'b1, 32'h1234, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_ws !== 5) begin failures++; $display("FAIL write_wait_waits got=%0d exp=5", r_ws); end
        checks++;
        if (r_err !== 1'b0 || r_rdata !== 32'h0) begin
            failures++; $display("FAIL write_wait_resp got=%h/%b exp=0/0", r_rdata, r_err);
        end
        checks++;
        if (r_bad !== 0) begin failures++; $display("FAIL write_wait_stable got=%0d bad cycles exp=0", r_bad); end
    endtask

    task automatic test_unmapped();
        run_xfer(32'h180, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_psel !== '0) begin failures++; $display("FAIL unmapped_psel got=%b exp=000", r_psel); end
        checks++;
        if (r_ws !== 0) begin failures++; $display("FAIL unmapped_waits got=%0d exp=0", r_ws); end
        checks++;
        if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
            failures++; $display("FAIL unmapped_resp got=%h/%b exp=0/1", r_rdata, r_err);
        end
    endtask

    task automatic test_slave_error();
        wait_cfg[0] = 0; rdata_cfg[0] = 32'h0BAD0BAD; err_cfg[0] = 1'b1;
        run_xfer(32'h10, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_err !== 1'b1 || r_ws !== 2) begin
            failures++; $display("FAIL slave_error got=%b/%0d exp=1/2", r_err, r_ws);
        end
        err_cfg[0] = 1'b0;
    endtask

    task automatic test_timeout();
        wait_cfg[0] = 1000; rdata_cfg[0] = 32'h11112222; err_cfg[0] = 1'b0;
`ifdef APB_DEMUX_TIMEOUT_EN
        run_xfer(32'h8, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_ws !== 5 || r_err !== 1'b1 || r_tmo !== 1'b1 || r_rdata !== 32'h0) begin
            failures++;
            $display("FAIL timeout_abort got ws=%0d err=%b tmo=%b rd=%h exp 5/1/1/0", r_ws, r_err, r_tmo, r_rdata);
        end
`else
        wait_cfg[0] = 20;
        run_xfer(32'h8, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_ws !== 22 || r_err !== 1'b0 || r_tmo !== 1'b0 || r_rdata !== 32'h11112222) begin
            failures++;
            $display("FAIL no_timeout_wait got ws=%0d err=%b tmo=%b rd=%h exp 22/0/0/11112222", r_ws, r_err, r_tmo, r_rdata);
        end
`endif
        checks++;
        if (r_bad !== 0) begin failures++; $display("FAIL timeout_bus got=%0d bad cycles exp=0", r_bad); end
        wait_cfg[0] = 0;
        run_xfer(32'hC, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_ws !== 2 || r_err !== 1'b0 || r_tmo !== 1'b0 || r_rdata !== 32'h11112222) begin
            failures++;
            $display("FAIL timeout_recover got ws=%0d err=%b tmo=%b rd=%h exp 2/0/0/11112222", r_ws, r_err, r_tmo, r_rdata);
        end
    endtask

    task automatic test_psel_drop();
        wait_cfg[2] = 1; rdata_cfg[2] = 32'h00D0D0D0; err_cfg[2] = 1'b0;
        run_xfer(32'h17C, 1'b0, 32'h0, 1'b1, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_ws !== 3 || r_rdata !== 32'h00D0D0D0 || r_bad !== 0) begin
            failures++; $display("FAIL psel_drop got ws=%0d rd=%h bad=%0d exp 3/00d0d0d0/0", r_ws, r_rdata, r_bad);
        end
    endtask

    task automatic test_reset_mid();
        wait_cfg[1] = 10; rdata_cfg[1] = 32'h76543210; err_cfg[1] = 1'b0;
        s_bus.psel = 1'b1; s_bus.penable = 1'b0; s_bus.pwrite = 1'b1;
        s_bus.paddr = 32'h90; s_bus.pwdata = 32'hFEEDBEEF;
        @(posedge PCLK);            // T0: upstream SETUP sampled
        #1 s_bus.penable = 1'b1;
        @(posedge PCLK);            // T1: downstream SETUP
        @(posedge PCLK);            // T2: downstream ACCESS
        #1 PRESETn = 1'b0;
        @(posedge PCLK);            // reset edge
        #1 s_bus.psel = 1'b0; s_bus.penable = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({s_bus.pready, s_bus.pslverr, s_bus.prdata, m_bus.psel, m_bus.penable,
             m_bus.pwrite, m_bus.paddr, m_bus.pwdata, timeout_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got psel=%b en=%b wr=%b addr=%h wd=%h rdy=%b exp all 0",
                     m_bus.psel, m_bus.penable, m_bus.pwrite, m_bus.paddr, m_bus.pwdata, s_bus.pready);
        end
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        wait_cfg[1] = 0;
        run_xfer(32'h88, 1'b0, 32'h0, 1'b0, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
        checks++;
        if (r_ws !== 2 || r_rdata !== 32'h76543210 || r_err !== 1'b0 || r_bad !== 0) begin
            failures++; $display("FAIL reset_mid_recover got ws=%0d rd=%h err=%b bad=%0d", r_ws, r_rdata, r_err, r_bad);
        end
    endtask

    task automatic test_random();
        int          e_ws;
        logic [31:0] e_rdata, addr, wdata;
        logic        e_err, e_tmo, write;
        bit          drop;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < SC; i++) begin
                wait_cfg[i]  = $urandom_range(0, 5);
                rdata_cfg[i] = $urandom;
                err_cfg[i]   = 1'($urandom_range(0, 3) == 0);
            end
            addr  = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 'h1FF)) & ~32'h3);
            write = 1'($urandom);
            wdata = $urandom;
            drop  = ($urandom_range(0, 7) == 0);
            model(addr, write, e_ws, e_rdata, e_err, e_tmo);
            run_xfer(addr, write, wdata, drop, r_ws, r_rdata, r_err, r_tmo, r_bad, r_psel, r_paddr);
            checks++;
            if (r_ws !== e_ws) begin
                failures++; $display("FAIL rand[%0d] waits addr=%h got=%0d exp=%0d", n, addr, r_ws, e_ws);
            end
            checks++;
            if (r_rdata !== e_rdata || r_err !== e_err || r_tmo !== e_tmo) begin
                failures++;
                $display("FAIL rand[%0d] resp addr=%h got=%h/%b/%b exp=%h/%b/%b",
                         n, addr, r_rdata, r_err, r_tmo, e_rdata, e_err, e_tmo);
            end
            checks++;
            if (r_bad !== 0) begin
                failures++; $display("FAIL rand[%0d] bus addr=%h got=%0d bad cycles exp=0", n, addr, r_bad);
            end
        end
    endtask

    initial begin
        s_bus.psel = 1'b0; s_bus.penable = 1'b0; s_bus.pwrite = 1'b0;
        s_bus.paddr = '0; s_bus.pwdata = '0;
        for (int i = 0; i < SC; i++) begin
            wait_cfg[i] = 0; rdata_cfg[i] = '0; err_cfg[i] = 1'b0;
        end
        test_reset();
        test_read_c1();
        test_write_wait();
        test_unmapped();
        test_slave_error();
        test_timeout();
        test_psel_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
